// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// Holds the FSM state encoding, access-size encodings and the IO window tag.
// The size helper maps a request size code to its byte count.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        IF_RD = 2'b01,
        LS_RD = 2'b10,
        LS_WR = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE     = 2'b00,
        SZ_HALF     = 2'b01,
        SZ_WORD     = 2'b10,
        SZ_WORD_ALT = 2'b11
    } size_t;

    // Address bits [17:16] equal to this value select the UART window.
    localparam logic [1:0] IO_ADDR_HI = 2'b11;

    // Number of bytes moved for a given size code.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_BYTE:     size_bytes = 3'd1;
            SZ_HALF:     size_bytes = 3'd2;
            SZ_WORD:     size_bytes = 3'd4;
            SZ_WORD_ALT: size_bytes = 3'd4;
            default:     size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb.sv
// Grant selection between instruction fetch and load/store (MEM_CTRL_RR_EN: round-robin).
// Latency: combinational grant; the round-robin pointer updates on the granting edge.
// Backpressure: grants only while en is high; a losing request simply stays pending.
module mem_arb (
`ifdef MEM_CTRL_RR_EN
    input  logic clk_in,
    input  logic rst_in,
`endif
    input  logic en,
    input  logic if_req,
    input  logic ls_req,
    output logic grant_if,
    output logic grant_ls
);

`ifdef MEM_CTRL_RR_EN
    // Set when the fetch side should win the next collision.
    logic favour_if;

    // Flip the favour after each collision so the last winner loses next time.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            favour_if <= 1'b0;
        end else if (en && if_req && ls_req) begin
            favour_if <= grant_ls;
        end
    end

    // Round-robin grant on collision, otherwise serve whoever asks.
    always_comb begin
        grant_ls = en && ls_req && (!if_req || !favour_if);
        grant_if = en && if_req && !grant_ls;
    end
`else
    // Fixed priority: load/store always beats fetch.
    always_comb begin
        grant_ls = en && ls_req;
        grant_if = en && if_req && !ls_req;
    end
`endif

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller serving fetch and load/store (optional MEM_CTRL_RR_EN arbitration).
// Latency: N-byte read done N+1 cycles after accept, N-byte write done N cycles after accept.
// Backpressure: rdy_in low freezes everything; IO writes hold each byte while io_buffer_full.
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  if_flush,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [1:0]            ls_size,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_done,
    output logic [31:0]           ls_rdata
);
    import mem_ctrl_pkg::*;

    state_t                state, state_n;
    logic [2:0]            cnt, len, cnt_inc, cnt_dec;
    logic [1:0]            cap_idx, nxt_idx;
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0]           wdata_q, rbuf, rbuf_n;
    logic                  wr_pend, is_io, paused, skip;
    logic                  arb_en, grant_if, grant_ls;
    logic                  rd_cap, rd_last, wr_last, redrive, flush_abort;

    // Read counter cnt=k means byte k-1 is due on mem_din at this edge.
    assign cnt_inc = cnt + 3'd1;
    assign cnt_dec = cnt - 3'd1;
    assign cap_idx = cnt_dec[1:0];
    assign nxt_idx = cnt_inc[1:0];
    assign arb_en  = (state == IDLE) && rdy_in;

    // A write byte goes out only when running and, for IO, when the UART has room.
    assign mem_wr = wr_pend && rdy_in && !(is_io && io_buffer_full);

    // The requester that just finished still holds req during its done cycle.
    mem_arb u_arb (
`ifdef MEM_CTRL_RR_EN
        .clk_in   (clk_in),
        .rst_in   (rst_in),
`endif
        .en       (arb_en),
        .if_req   (if_req && !if_done && !if_flush),
        .ls_req   (ls_req && !ls_done),
        .grant_if (grant_if),
        .grant_ls (grant_ls)
    );

    // Read buffer with the byte currently on mem_din merged into its lane.
    always_comb begin
        rbuf_n = rbuf;
        rbuf_n[{cap_idx, 3'b000} +: 8] = mem_din;
    end

    // Next-state and per-edge strobes; nothing moves while rdy_in is low.
    always_comb begin
        state_n     = state;
        rd_cap      = 1'b0;
        rd_last     = 1'b0;
        wr_last     = 1'b0;
        redrive     = 1'b0;
        flush_abort = 1'b0;
        if (rdy_in) begin
            case (state)
                IDLE: begin
                    if (grant_ls)      state_n = ls_we ? LS_WR : LS_RD;
                    else if (grant_if) state_n = IF_RD;
                end
                IF_RD, LS_RD: begin
                    if (state == IF_RD && if_flush) begin
                        flush_abort = 1'b1;
                        state_n     = IDLE;
                    end else if (paused) begin
                        redrive = 1'b1;
                    end else begin
                        rd_cap  = (cnt != 3'd0) && !skip;
                        rd_last = rd_cap && (cnt == len);
                        if (rd_last) state_n = IDLE;
                    end
                end
                LS_WR: begin
                    if (mem_wr && cnt_inc == len) begin
                        wr_last = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_n;
    end

    // Address sequencing, byte capture/issue and completion pulses.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt      <= 3'd0;
            len      <= 3'd0;
            base     <= '0;
            wdata_q  <= '0;
            rbuf     <= '0;
            wr_pend  <= 1'b0;
            is_io    <= 1'b0;
            paused   <= 1'b0;
            skip     <= 1'b0;
            mem_a    <= '0;
            mem_dout <= '0;
            if_done  <= 1'b0;
            ls_done  <= 1'b0;
            if_data  <= '0;
            ls_rdata <= '0;
        end else begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            paused  <= !rdy_in;
            if (rdy_in) begin
                case (state)
                    IDLE: begin
                        if (grant_ls) begin
                            base     <= ls_addr;
                            mem_a    <= ls_addr;
                            len      <= size_bytes(ls_size);
                            cnt      <= 3'd0;
                            skip     <= 1'b0;
                            rbuf     <= '0;
                            wdata_q  <= ls_wdata;
                            mem_dout <= ls_wdata[7:0];
                            wr_pend  <= ls_we;
                            is_io    <= ls_we && (ls_addr[17:16] == IO_ADDR_HI);
                        end else if (grant_if) begin
                            base    <= if_addr;
                            mem_a   <= if_addr;
                            len     <= 3'd4;
                            cnt     <= 3'd0;
                            skip    <= 1'b0;
                            rbuf    <= '0;
                            wr_pend <= 1'b0;
                            is_io   <= 1'b0;
                        end
                    end
                    IF_RD, LS_RD: begin
                        if (flush_abort) begin
                            cnt <= 3'd0;
                        end else if (redrive) begin
                            // Data seen during the pause was lost: put the pending
                            // byte's address back out and skip one capture.
                            if (skip || cnt == 3'd0) begin
                                mem_a <= base + ADDR_WIDTH'(cnt);
                            end else begin
                                mem_a <= base + ADDR_WIDTH'(cnt_dec);
                                cnt   <= cnt_dec;
                                skip  <= 1'b1;
                            end
                        end else begin
                            if (rd_cap) rbuf <= rbuf_n;
                            if (rd_last) begin
                                if (state == IF_RD) begin
                                    if_data <= rbuf_n;
                                    if_done <= 1'b1;
                                end else begin
                                    ls_rdata <= rbuf_n;
                                    ls_done  <= 1'b1;
                                end
                            end else begin
                                if (cnt_inc < len) mem_a <= base + ADDR_WIDTH'(cnt_inc);
                                cnt  <= cnt_inc;
                                skip <= 1'b0;
                            end
                        end
                    end
                    LS_WR: begin
                        if (mem_wr) begin
                            if (wr_last) begin
                                wr_pend <= 1'b0;
                                ls_done <= 1'b1;
                            end else begin
                                cnt      <= cnt_inc;
                                mem_a    <= mem_a + 1'b1;
                                mem_dout <= wdata_q[{nxt_idx, 3'b000} +: 8];
                            end
                        end
                    end
                    default: cnt <= 3'd0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a registered-read byte memory model (MEM_CTRL_RR_EN aware).
// Latency: checks are taken 2 time units after each rising edge.
// Backpressure: exercises rdy_in pauses, io_buffer_full stalls and fetch flush.
module tb_mem_ctrl;

    logic        clk;
    logic        rst_in, rdy_in;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;
    logic        if_req, if_done, if_flush;
    logic [31:0] if_addr, if_data;
    logic        ls_req, ls_we, ls_done;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [1:0]  ls_size;

    int n_chk  = 0;
    int n_fail = 0;
    int n;

    mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .if_flush       (if_flush),
        .ls_req         (ls_req),
        .ls_we          (ls_we),
        .ls_addr        (ls_addr),
        .ls_size        (ls_size),
        .ls_wdata       (ls_wdata),
        .ls_done        (ls_done),
        .ls_rdata       (ls_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: the fetch word at 0x1000 plus an address-derived pattern.
    function automatic logic [7:0] mb(input logic [31:0] a);
        case (a)
            32'h1000: mb = 8'h13;
            32'h1001: mb = 8'h00;
            32'h1002: mb = 8'h50;
            32'h1003: mb = 8'h00;
            default:  mb = a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] mword(input logic [31:0] a);
        mword = {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
    endfunction

    // Registered-read memory: data appears the cycle after its address.
    always @(posedge clk) mem_din <= mb(mem_a);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Steps until the selected done pulse is seen; n is edges taken (capped at max).
    task automatic run_until(input bit on_ls, input int max, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!(on_ls ? ls_done : if_done) && cnt < max);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_size = 2'b00; ls_wdata = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
        chk("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
        chk("rst_dones", {30'b0, if_done, ls_done}, 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_ls_rdata", ls_rdata, 32'h0);
        rst_in = 1'b0;

        // Fetch at 0x1000.
        if_req = 1'b1; if_addr = 32'h1000;
        step();
        chk("fetch_addr0", mem_a, 32'h1000);
        chk("fetch_wr", {31'b0, mem_wr}, 32'h0);
        run_until(1'b0, 20, n);
        chk("fetch_latency", n, 5);
        chk("fetch_data", if_data, 32'h0050_0013);
        step();
        chk("fetch_done_pulse", {31'b0, if_done}, 32'h0);
        chk("fetch_no_rearb", mem_a, 32'h1003);
        if_req = 1'b0;
        step();

        // Collision: load/store wins first, fetch follows after one idle cycle.
        if_req = 1'b1; if_addr = 32'h80;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40; ls_size = 2'b10;
        step();
        chk("coll1_ls_first", mem_a, 32'h40);
        run_until(1'b1, 20, n);
        chk("coll1_ls_latency", n, 5);
        chk("coll1_ls_data", ls_rdata, mword(32'h40));
        step();
        chk("coll1_if_next", mem_a, 32'h80);
        ls_req = 1'b0;
        run_until(1'b0, 20, n);
        chk("coll1_if_latency", n, 5);
        chk("coll1_if_data", if_data, mword(32'h80));
        if_req = 1'b0;
        step();

        // Second collision.
        if_req = 1'b1; if_addr = 32'h84;
        ls_req = 1'b1; ls_addr = 32'h44; ls_size = 2'b11;
        step();
`ifdef MEM_CTRL_RR_EN
        chk("coll2_rr_if_first", mem_a, 32'h84);
        run_until(1'b0, 20, n);
        chk("coll2_if_data", if_data, mword(32'h84));
        if_req = 1'b0;
        step();
        chk("coll2_ls_next", mem_a, 32'h44);
        run_until(1'b1, 20, n);
        chk("coll2_ls_data", ls_rdata, mword(32'h44));
        ls_req = 1'b0;
`else
        chk("coll2_fixed_ls_first", mem_a, 32'h44);
        run_until(1'b1, 20, n);
        chk("coll2_ls_data", ls_rdata, mword(32'h44));
        ls_req = 1'b0;
        step();
        chk("coll2_if_next", mem_a, 32'h84);
        run_until(1'b0, 20, n);
        chk("coll2_if_data", if_data, mword(32'h84));
        if_req = 1'b0;
`endif
        step();

        // Half-word store 0xBEEF at 0x200.
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b01; ls_addr = 32'h200; ls_wdata = 32'h0000_BEEF;
        step();
        chk("half_a0", mem_a, 32'h200);
        chk("half_d0", {24'b0, mem_dout}, 32'hEF);
        chk("half_wr0", {31'b0, mem_wr}, 32'h1);
        step();
        chk("half_a1", mem_a, 32'h201);
        chk("half_d1", {24'b0, mem_dout}, 32'hBE);
        chk("half_wr1", {31'b0, mem_wr}, 32'h1);
        chk("half_nodone1", {31'b0, ls_done}, 32'h0);
        step();
        chk("half_wr_end", {31'b0, mem_wr}, 32'h0);
        chk("half_done", {31'b0, ls_done}, 32'h1);
        ls_req = 1'b0;
        step();

        // IO byte store with the UART full for three cycles.
        io_buffer_full = 1'b1;
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b00; ls_addr = 32'h3_0000; ls_wdata = 32'h41;
        step();
        chk("io_addr", mem_a, 32'h3_0000);
        chk("io_dout", {24'b0, mem_dout}, 32'h41);
        chk("io_hold0", {31'b0, mem_wr}, 32'h0);
        step();
        chk("io_hold1", {31'b0, mem_wr}, 32'h0);
        step();
        chk("io_hold2", {31'b0, mem_wr}, 32'h0);
        io_buffer_full = 1'b0;
        #1;
        chk("io_issue", {31'b0, mem_wr}, 32'h1);
        step();
        chk("io_done", {31'b0, ls_done}, 32'h1);
        chk("io_wr_end", {31'b0, mem_wr}, 32'h0);
        ls_req = 1'b0;
        step();

        // Flush on the second fetch byte; pending load accepted right after.
        if_req = 1'b1; if_addr = 32'h300;
        step();
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b00; ls_addr = 32'h50;
        step();
        chk("flush_byte1_addr", mem_a, 32'h301);
        if_flush = 1'b1;
        step();
        chk("flush_no_done", {31'b0, if_done}, 32'h0);
        if_flush = 1'b0; if_req = 1'b0;
        step();
        chk("flush_ls_accept", mem_a, 32'h50);
        chk("flush_no_done2", {31'b0, if_done}, 32'h0);
        run_until(1'b1, 20, n);
        chk("byte_rd_latency", n, 2);
        chk("byte_rd_zext", ls_rdata, {24'b0, mb(32'h50)});
        ls_req = 1'b0;
        step();

        // Word load paused for four cycles after its third edge.
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h120;
        step();
        step();
        step();
        rdy_in = 1'b0;
        repeat (4) step();
        chk("pause_addr_held", mem_a, 32'h122);
        chk("pause_no_done", {31'b0, ls_done}, 32'h0);
        rdy_in = 1'b1;
        step();
        chk("pause_redrive", mem_a, 32'h121);
        run_until(1'b1, 20, n);
        chk("pause_latency", 3 + 4 + n, 11);
        chk("pause_data", ls_rdata, mword(32'h120));
        ls_req = 1'b0;
        step();

        // Byte store held off by rdy_in.
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b00; ls_addr = 32'h10; ls_wdata = 32'h77;
        step();
        rdy_in = 1'b0;
        #1;
        chk("frz_wr0", {31'b0, mem_wr}, 32'h0);
        step();
        step();
        chk("frz_wr1", {31'b0, mem_wr}, 32'h0);
        chk("frz_nodone", {31'b0, ls_done}, 32'h0);
        rdy_in = 1'b1;
        #1;
        chk("frz_resume_wr", {31'b0, mem_wr}, 32'h1);
        chk("frz_dout", {24'b0, mem_dout}, 32'h77);
        step();
        chk("frz_done", {31'b0, ls_done}, 32'h1);
        ls_req = 1'b0; ls_we = 1'b0;
        step();

        // Fetch across the top of the address space.
        if_req = 1'b1; if_addr = 32'hFFFF_FFFE;
        step();
        step();
        chk("wrap_a1", mem_a, 32'hFFFF_FFFF);
        step();
        chk("wrap_a2", mem_a, 32'h0);
        run_until(1'b0, 20, n);
        chk("wrap_latency", 2 + n, 5);
        chk("wrap_data", if_data, mword(32'hFFFF_FFFE));
        if_req = 1'b0;
        step();

        // Reset in the middle of a fetch.
        if_req = 1'b1; if_addr = 32'h1000;
        step();
        step();
        rst_in = 1'b1;
        #1;
        chk("rst_mid_mem_a", mem_a, 32'h0);
        chk("rst_mid_if_data", if_data, 32'h0);
        chk("rst_mid_ls_rdata", ls_rdata, 32'h0);
        chk("rst_mid_dout", {24'b0, mem_dout}, 32'h0);
        if_req = 1'b0;
        step();
        rst_in = 1'b0;
        n = 0;
        repeat (6) begin
            step();
            if (if_done) n++;
        end
        chk("rst_mid_no_done", n, 0);
        chk("rst_mid_idle_addr", mem_a, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, width of all address ports.
REQ-002 clk_in  input  1  system clock; all state on rising edge.
REQ-003 rst_in  input  1  reset; asynchronous, active-high.
REQ-004 rdy_in  input  1  global ready; low freezes the block.
REQ-005 mem_din  input  8  memory read byte; valid one cycle after its address.
REQ-006 mem_dout  output  8  memory write byte.
REQ-007 mem_a  output  ADDR_WIDTH  memory byte address.
REQ-008 mem_wr  output  1  1 = write, 0 = read.
REQ-009 io_buffer_full  input  1  UART tx buffer full.
REQ-010 if_req / if_addr  input  1 / ADDR_WIDTH  instruction fetch request, level-held until if_done; 4-byte read.
REQ-011 if_done / if_data  output  1 / 32  one-cycle completion pulse and little-endian word.
REQ-012 if_flush  input  1  abort any fetch in progress.
REQ-013 ls_req / ls_we / ls_addr / ls_size / ls_wdata  input  1 / 1 / ADDR_WIDTH / 2 / 32  load/store request, level-held until ls_done; size 00 = byte, 01 = half, 10 and 11 = word.
REQ-014 ls_done / ls_rdata  output  1 / 32  one-cycle completion pulse; read data zero-extended.

Function
REQ-015 The FSM states SHALL be IDLE, IF_RD, LS_RD and LS_WR; arbitration happens only in IDLE.
REQ-016 When both requests are pending in IDLE, LSU SHALL win (fixed priority, unless REQ-031 applies).
REQ-017 Accepting edge: latch address, size and data; drive mem_a = base, mem_wr per type.
REQ-018 Byte k SHALL be addressed at base+k, with mem_din captured one cycle later into bits [8k+7:8k].
REQ-019 An N-byte read SHALL pulse done exactly N+1 cycles after the accepting edge (fetch: 5).
REQ-020 An N-byte write SHALL drive mem_dout = wdata[8k+7:8k], mem_wr = 1 for byte k, and pulse done N cycles after acceptance.
REQ-021 After done, the FSM SHALL return to IDLE; the controller SHALL ignore the finishing requester's req in the done cycle, leaving one IDLE cycle between transactions.
REQ-022 For an IO write (addr[17:16] == 2'b11), each byte SHALL be held with mem_wr = 0 while io_buffer_full = 1, and issued on the first cycle it is 0.
REQ-023 Outside LS_WR, mem_wr SHALL be 0.
REQ-024 if_flush in IF_RD SHALL return the FSM to IDLE on the next edge with no if_done.
REQ-025 if_flush in IDLE SHALL block fetch arbitration that cycle; in LS_RD or LS_WR it SHALL be ignored.
REQ-026 While rdy_in = 0, all state, counters and captured data SHALL be frozen and mem_wr SHALL be 0.
REQ-027 On resume, the last byte address SHALL be re-driven one cycle before its data is captured.
REQ-028 Address increment SHALL wrap modulo 2^ADDR_WIDTH.

Reset
REQ-029 On rst_in, the FSM SHALL enter IDLE, all counters SHALL clear, and mem_a, mem_dout, mem_wr, if_done, ls_done, if_data and ls_rdata SHALL be 0.
REQ-030 A transaction in flight when rst_in asserts SHALL be abandoned with no done pulse.

Configuration
REQ-031 With MEM_CTRL_RR_EN defined, simultaneous requests SHALL alternate grant (round-robin, last-granted loses, initial favour LSU); without it, LSU fixed priority SHALL apply.

Structure
REQ-032 Package mem_ctrl_pkg SHALL hold the state enum, the size encodings and IO_ADDR_HI = 2'b11.
REQ-033 The grant logic SHALL be the sub-module mem_arb; byte sequencing stays in mem_ctrl.

Verification
REQ-034 if_req at 0x1000 returning bytes 13,00,50,00 -> if_done 5 cycles after acceptance, if_data = 0x00500013.
REQ-035 if_req and ls_req (word read) in the same cycle -> LSU served first, then one IDLE cycle, then fetch; with MEM_CTRL_RR_EN, a second collision grants fetch.
REQ-036 ls_we, size 01, addr 0x200, wdata 0xBEEF -> mem_a 0x200/0x201, mem_dout EF/BE, mem_wr = 1 two cycles, ls_done at +2.
REQ-037 Byte write 0x41 to 0x30000 with io_buffer_full held 3 cycles -> mem_wr stays 0 for 3 cycles, then 1 cycle; ls_done one cycle later.
REQ-038 if_flush on the 2nd byte of a fetch -> no if_done, IDLE next edge; a pending ls_req is accepted on the following edge.
REQ-039 rdy_in low 4 cycles mid-word-read -> ls_rdata identical to an unpaused run; latency extended by 4 plus re-drive.
